my_cpu_lsu: RTL and testbench
=============================

Name: my_cpu_lsu

Overview:
- Load/store unit directly downstream of the control decoder's MemRW/CPU_MIO outputs and the ALU address. Sits between the single-cycle datapath and the MIO bus.
- Turns one memory instruction into a bus transaction that waits on MIO_ready.
- Generates byte enables and lane-replicated store data, and aligns and extends load data.
- Stalls the datapath until the access completes, errors, or times out.

Parameters:
- TIMEOUT, 255, max cycles spent waiting in BUSY for MIO_ready before a bus error; valid range 1..1023.
- ADDR_W, 32, address width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- mem_req  in  1  current instruction is a load or store (load opcode or MemRW=1).
- MemRW  in  1  1 = store, 0 = load.
- Fun3  in  3  instruction[14:12]: width and signedness.
- addr  in  ADDR_W  effective address from the ALU.
- wdata  in  32  rs2 store data.
- MIO_ready  in  1  bus completion strobe.
- Data_in  in  32  bus read data, valid when MIO_ready=1.
- bus_req  out  1  bus transaction active (drives CPU_MIO).
- bus_we  out  1  bus write.
- Addr_out  out  ADDR_W  word-aligned bus address ({addr[31:2],2'b00}).
- Data_out  out  32  lane-replicated store data.
- byte_en  out  4  byte lane enables.
- load_data  out  32  aligned, extended load result.
- load_valid  out  1  load_data valid; writeback strobe.
- stall  out  1  hold PC and pipeline inputs.
- misalign  out  1  one-cycle pulse: misaligned or illegal access.
- bus_err  out  1  one-cycle pulse: timeout.

Behaviour:
- Reset (rst_n=0 at an edge), including mid-transaction:
  - state=IDLE, timeout counter=0.
  - All outputs 0: bus_req, bus_we, Addr_out, Data_out, byte_en, load_data, load_valid, misalign, bus_err. stall=0 on the following cycle.
  - A pending MIO_ready is dropped.
- Handshake rule: upstream holds mem_req, MemRW, Fun3, addr and wdata stable while stall=1.
- stall is combinational: (state==IDLE && mem_req && access legal) || state==BUSY.
- Legality, evaluated in IDLE:
  - Fun3 011, 110, 111 are illegal.
  - Stores with Fun3 1xx are illegal.
  - Halfword requires addr[0]=0; word requires addr[1:0]=00.
  - An illegal access raises misalign for exactly one cycle (registered, so it appears the cycle after request), with no bus access and no stall.
- States:
  - IDLE, on mem_req and legal: latch Addr_out, byte_en, Data_out, bus_we, Fun3 and addr[1:0]. Set bus_req=1, clear the counter, go to BUSY.
  - BUSY: bus_req held.
    - MIO_ready=1: bus_req=0. For a load, register the aligned result into load_data. Go to DONE.
    - Otherwise the counter increments. At counter==TIMEOUT-1 with no ready: bus_req=0, load_data=0, bus_err pulses, go to DONE.
    - MIO_ready arriving in the same cycle as the timeout wins: normal completion, no error.
  - DONE: stall=0 and load_valid=1 for this one cycle (loads only). mem_req is ignored because it is the same instruction retiring. Next state is IDLE.
- MIO_ready while in IDLE or DONE is ignored.
- Latency with zero-wait bus (MIO_ready high during the first BUSY cycle): request cycle, BUSY, DONE. Three cycles total, two of them stalled.
- Store lanes:
  - SB: Data_out={4{wdata[7:0]}}, byte_en=0001<<addr[1:0].
  - SH: Data_out={2{wdata[15:0]}}, byte_en=0011<<addr[1:0].
  - SW: Data_out=wdata, byte_en=1111.
- Loads: byte_en=1111. Lane select uses the latched addr[1:0].
  - LB/LH: sign-extended.
  - LBU/LHU: zero-extended.
  - LW: passed through.

Decomposition:
- Shared package cpu_pkg holds:
  - Fun3 width encodings: F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101.
  - LSU state enum: IDLE, BUSY, DONE.
  - TIMEOUT default.
- One combinational sub-module, lsu_align, handles store lane replication, byte_en generation, the legality check and load extract/extend.
- The FSM, counter and registers stay in my_cpu_lsu.

Test Plan:
- LW addr=0x100, MIO_ready high on the first BUSY cycle, Data_in=0xDEADBEEF: stall 2 cycles, Addr_out=0x100, byte_en=1111; in DONE load_valid=1 and load_data=0xDEADBEEF.
- LB addr=0x103, Data_in=0x80FF1234: load_data=0xFFFFFF80. Same access as LBU gives 0x00000080. LH at 0x102 gives 0xFFFF80FF.
- SB addr=0x201, wdata=0x000000A5, ready after 3 wait cycles: bus_we=1, byte_en=0010, Data_out=0xA5A5A5A5, stall 5 cycles, load_valid stays 0.
- SW addr=0x202: misalign pulses once, bus_req never asserts, stall=0. Fun3=011 behaves the same.
- TIMEOUT=4, load with MIO_ready never asserted: bus_req deasserts after 4 BUSY cycles, bus_err=1 and load_data=0 in DONE. Repeat with ready arriving exactly on the 4th BUSY cycle: no bus_err.
- rst_n=0 during BUSY: next cycle state=IDLE, bus_req=0, stall=0. A MIO_ready arriving afterwards produces no load_valid.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the CPU load/store path.
//   - Fun3 width/signedness encodings (instruction[14:12])
//   - LSU state enumeration
//   - default bus timeout and the timeout counter width
package cpu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Cycles allowed in BUSY waiting for MIO_ready (legal range 1..1023).
  localparam int TIMEOUT_DEFAULT = 255;
  localparam int CNT_W           = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// lsu_align: purely combinational lane logic for the load/store unit.
// Ports:
//   fun3, addr_lo, is_store, wdata   - live request (evaluated in IDLE)
//   legal                            - access is encodable and aligned
//   byte_en, store_data              - lane enables and replicated store data
//   rd_fun3, rd_addr_lo, rdata       - latched access info and bus read data
//   load_result                      - selected lane, sign/zero extended
module lsu_align
  import cpu_pkg::*;
(
  input  logic [2:0]  fun3,
  input  logic [1:0]  addr_lo,
  input  logic        is_store,
  input  logic [31:0] wdata,
  input  logic [2:0]  rd_fun3,
  input  logic [1:0]  rd_addr_lo,
  input  logic [31:0] rdata,
  output logic        legal,
  output logic [3:0]  byte_en,
  output logic [31:0] store_data,
  output logic [31:0] load_result
);

  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  // Legality: unsigned widths exist only for loads; halfwords need
  // 2-byte alignment, words need 4-byte alignment.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path
    // leaves it unassigned, which would infer a latch.
    legal = 1'b0;
    case (fun3)
      F3_B:    legal = 1'b1;
      F3_H:    legal = ~addr_lo[0];
      F3_W:    legal = (addr_lo == 2'b00);
      F3_BU:   legal = ~is_store;
      F3_HU:   legal = ~is_store & ~addr_lo[0];
      default: legal = 1'b0;
    endcase
  end

  // Stores replicate the datum across every lane so the bus slave can
  // pick it up from whichever lane byte_en selects. Loads read all lanes.
  always_comb begin
    byte_en    = 4'b1111;
    store_data = wdata;
    if (is_store) begin
      case (fun3[1:0])
        2'b00: begin
          store_data = {4{wdata[7:0]}};
          byte_en    = 4'b0001 << addr_lo;
        end
        2'b01: begin
          store_data = {2{wdata[15:0]}};
          byte_en    = 4'b0011 << addr_lo;
        end
        default: begin
          store_data = wdata;
          byte_en    = 4'b1111;
        end
      endcase
    end
  end

  // Load extract uses the address/width latched at request time, since the
  // read data arrives cycles later.
  always_comb begin
    case (rd_addr_lo)
      2'd0:    rbyte = rdata[7:0];
      2'd1:    rbyte = rdata[15:8];
      2'd2:    rbyte = rdata[23:16];
      default: rbyte = rdata[31:24];
    endcase
    rhalf = rd_addr_lo[1] ? rdata[31:16] : rdata[15:0];

    case (rd_fun3)
      F3_B:    load_result = {{24{rbyte[7]}}, rbyte};
      F3_BU:   load_result = {24'h0, rbyte};
      F3_H:    load_result = {{16{rhalf[15]}}, rhalf};
      F3_HU:   load_result = {16'h0, rhalf};
      default: load_result = rdata;
    endcase
  end

endmodule

// File: rtl/my_cpu_lsu.sv
// my_cpu_lsu: load/store unit between the single-cycle datapath and the
// MIO bus. One memory instruction becomes one bus transaction; the datapath
// is stalled until MIO_ready, or until TIMEOUT cycles pass (bus_err).
// Ports:
//   clk, rst_n                      - clock, synchronous active-low reset
//   mem_req, MemRW, Fun3, addr,     - request from decoder/ALU/regfile,
//   wdata                             held stable while stall=1
//   MIO_ready, Data_in              - bus completion strobe and read data
//   bus_req, bus_we, Addr_out,      - bus transaction (registered)
//   Data_out, byte_en
//   load_data, load_valid           - load writeback (valid in DONE)
//   stall                           - combinational pipeline hold
//   misalign, bus_err               - one-cycle error pulses
module my_cpu_lsu
  import cpu_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT,
  parameter int ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_req,
  input  logic              MemRW,
  input  logic [2:0]        Fun3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  input  logic              MIO_ready,
  input  logic [31:0]       Data_in,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] Addr_out,
  output logic [31:0]       Data_out,
  output logic [3:0]        byte_en,
  output logic [31:0]       load_data,
  output logic              load_valid,
  output logic              stall,
  output logic              misalign,
  output logic              bus_err
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  lsu_state_e       state, state_next;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       fun3_q;
  logic [1:0]       addr_lo_q;

  logic             legal;
  logic [3:0]       align_be;
  logic [31:0]      align_wd;
  logic [31:0]      align_ld;

  logic             start;
  logic             bad_req;
  logic             finish;
  logic             expire;

  lsu_align u_align (
    .fun3        (Fun3),
    .addr_lo     (addr[1:0]),
    .is_store    (MemRW),
    .wdata       (wdata),
    .rd_fun3     (fun3_q),
    .rd_addr_lo  (addr_lo_q),
    .rdata       (Data_in),
    .legal       (legal),
    .byte_en     (align_be),
    .store_data  (align_wd),
    .load_result (align_ld)
  );

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: state updates use non-blocking assignments, and the reset is
    // sampled here on the clock edge rather than in the sensitivity list.
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next state and control strobes. MIO_ready is only looked at in BUSY;
  // a ready coinciding with the last timeout cycle completes normally.
  always_comb begin
    state_next = state;
    stall      = 1'b0;
    start      = 1'b0;
    bad_req    = 1'b0;
    finish     = 1'b0;
    expire     = 1'b0;
    case (state)
      IDLE: begin
        if (mem_req) begin
          if (legal) begin
            start      = 1'b1;
            stall      = 1'b1;
            state_next = BUSY;
          end else begin
            bad_req = 1'b1;
          end
        end
      end
      BUSY: begin
        stall = 1'b1;
        if (MIO_ready) begin
          finish     = 1'b1;
          state_next = DONE;
        end else if (cnt == CNT_LAST) begin
          expire     = 1'b1;
          state_next = DONE;
        end
      end
      // The instruction retires here; its mem_req is still high and must
      // not launch a second access.
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Bus registers, timeout counter and result/pulse outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus_req    <= 1'b0;
      bus_we     <= 1'b0;
      Addr_out   <= '0;
      Data_out   <= '0;
      byte_en    <= '0;
      load_data  <= '0;
      load_valid <= 1'b0;
      misalign   <= 1'b0;
      bus_err    <= 1'b0;
      cnt        <= '0;
      fun3_q     <= '0;
      addr_lo_q  <= '0;
    end else begin
      // Pulses default low so each lasts exactly one cycle.
      load_valid <= 1'b0;
      misalign   <= 1'b0;
      bus_err    <= 1'b0;

      if (start) begin
        bus_req   <= 1'b1;
        bus_we    <= MemRW;
        Addr_out  <= {addr[ADDR_W-1:2], 2'b00};
        Data_out  <= align_wd;
        byte_en   <= align_be;
        fun3_q    <= Fun3;
        addr_lo_q <= addr[1:0];
        cnt       <= '0;
      end

      if (bad_req) misalign <= 1'b1;

      if (finish) begin
        bus_req    <= 1'b0;
        load_valid <= ~bus_we;
        if (!bus_we) load_data <= align_ld;
      end else if (expire) begin
        bus_req    <= 1'b0;
        load_valid <= ~bus_we;
        load_data  <= '0;
        bus_err    <= 1'b1;
      end else if (state == BUSY) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_my_cpu_lsu.sv
// tb_my_cpu_lsu: directed self-checking bench for my_cpu_lsu (TIMEOUT=4).
module tb_my_cpu_lsu;
  import cpu_pkg::*;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_req;
  logic        MemRW;
  logic [2:0]  Fun3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        MIO_ready;
  logic [31:0] Data_in;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] Addr_out;
  logic [31:0] Data_out;
  logic [3:0]  byte_en;
  logic [31:0] load_data;
  logic        load_valid;
  logic        stall;
  logic        misalign;
  logic        bus_err;

  my_cpu_lsu #(.TIMEOUT(TO), .ADDR_W(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mem_req    (mem_req),
    .MemRW      (MemRW),
    .Fun3       (Fun3),
    .addr       (addr),
    .wdata      (wdata),
    .MIO_ready  (MIO_ready),
    .Data_in    (Data_in),
    .bus_req    (bus_req),
    .bus_we     (bus_we),
    .Addr_out   (Addr_out),
    .Data_out   (Data_out),
    .byte_en    (byte_en),
    .load_data  (load_data),
    .load_valid (load_valid),
    .stall      (stall),
    .misalign   (misalign),
    .bus_err    (bus_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Observations from the most recent access.
  int          r_stalls;
  int          r_busy;
  logic        r_lv, r_err, r_we, r_done;
  logic [31:0] r_ld, r_dout, r_aout;
  logic [3:0]  r_be;

  // Issue one access; MIO_ready is raised during BUSY cycle waits+1
  // (waits<0: never). Samples on negedges until stall drops (DONE).
  task automatic access(input logic st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] din, input int waits);
    @(posedge clk); #1;
    mem_req = 1'b1; MemRW = st; Fun3 = f3; addr = a; wdata = wd;
    Data_in = din; MIO_ready = 1'b0;
    r_stalls = 0; r_busy = 0; r_lv = 1'b0; r_err = 1'b0; r_we = 1'b0;
    r_done = 1'b0; r_ld = '0; r_dout = '0; r_aout = '0; r_be = '0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus_req) begin
        r_busy++;
        r_we = bus_we; r_dout = Data_out; r_aout = Addr_out; r_be = byte_en;
      end
      if (stall) r_stalls++;
      else begin
        r_lv = load_valid; r_ld = load_data; r_err = bus_err; r_done = 1'b1;
        break;
      end
      MIO_ready = bus_req && (r_busy == waits + 1);
    end
    check("access_completes", {31'b0, r_done}, 32'd1);
    MIO_ready = 1'b0;
    @(posedge clk); #1;
    mem_req = 1'b0;
  endtask

  // Issue an illegal access for one cycle and watch the following cycles.
  task automatic bad_access(input string tag, input logic st, input logic [2:0] f3,
                            input logic [31:0] a);
    int   mis;
    logic breq, stl;
    @(posedge clk); #1;
    mem_req = 1'b1; MemRW = st; Fun3 = f3; addr = a; wdata = 32'h1111_2222;
    @(negedge clk);
    mis = int'(misalign); breq = bus_req; stl = stall;
    @(posedge clk); #1;
    mem_req = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      mis += int'(misalign); breq |= bus_req; stl |= stall;
    end
    check({tag, "_misalign_pulses"}, mis, 1);
    check({tag, "_bus_req"}, {31'b0, breq}, 32'd0);
    check({tag, "_stall"}, {31'b0, stl}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lv_seen;
    rst_n = 1'b0; mem_req = 1'b0; MemRW = 1'b0; Fun3 = F3_W; addr = '0;
    wdata = '0; MIO_ready = 1'b0; Data_in = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_bus_req",    {31'b0, bus_req},    32'd0);
    check("rst_stall",      {31'b0, stall},      32'd0);
    check("rst_load_valid", {31'b0, load_valid}, 32'd0);
    check("rst_byte_en",    {28'b0, byte_en},    32'd0);
    check("rst_data_out",   Data_out,            32'd0);
    check("rst_addr_out",   Addr_out,            32'd0);
    check("rst_load_data",  load_data,           32'd0);
    check("rst_pulses",     {30'b0, misalign, bus_err}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // LW, zero-wait bus.
    access(1'b0, F3_W, 32'h100, 32'h0, 32'hDEAD_BEEF, 0);
    check("lw_stalls",     r_stalls, 2);
    check("lw_addr_out",   r_aout, 32'h100);
    check("lw_byte_en",    {28'b0, r_be}, 32'hF);
    check("lw_bus_we",     {31'b0, r_we}, 32'd0);
    check("lw_load_valid", {31'b0, r_lv}, 32'd1);
    check("lw_load_data",  r_ld, 32'hDEAD_BEEF);

    // Lane extraction and extension.
    access(1'b0, F3_B, 32'h103, 32'h0, 32'h80FF_1234, 0);
    check("lb_103",      r_ld, 32'hFFFF_FF80);
    check("lb_addr_out", r_aout, 32'h100);
    access(1'b0, F3_BU, 32'h103, 32'h0, 32'h80FF_1234, 0);
    check("lbu_103", r_ld, 32'h0000_0080);
    access(1'b0, F3_H, 32'h102, 32'h0, 32'h80FF_1234, 0);
    check("lh_102", r_ld, 32'hFFFF_80FF);
    access(1'b0, F3_HU, 32'h102, 32'h0, 32'h80FF_1234, 0);
    check("lhu_102", r_ld, 32'h0000_80FF);
    access(1'b0, F3_B, 32'h101, 32'h0, 32'h80FF_1234, 1);
    check("lb_101", r_ld, 32'h0000_0012);

    // SB with three wait cycles.
    access(1'b1, F3_B, 32'h201, 32'h0000_00A5, 32'h0, 3);
    check("sb_bus_we",     {31'b0, r_we}, 32'd1);
    check("sb_byte_en",    {28'b0, r_be}, 32'b0010);
    check("sb_data_out",   r_dout, 32'hA5A5_A5A5);
    check("sb_addr_out",   r_aout, 32'h200);
    check("sb_stalls",     r_stalls, 5);
    check("sb_load_valid", {31'b0, r_lv}, 32'd0);
    check("sb_bus_err",    {31'b0, r_err}, 32'd0);

    // SH upper half.
    access(1'b1, F3_H, 32'h202, 32'h1234_ABCD, 32'h0, 0);
    check("sh_byte_en",  {28'b0, r_be}, 32'b1100);
    check("sh_data_out", r_dout, 32'hABCD_ABCD);

    // Illegal accesses.
    bad_access("sw_202",   1'b1, F3_W,   32'h202);
    bad_access("f3_011",   1'b0, 3'b011, 32'h100);
    bad_access("sbu",      1'b1, F3_BU,  32'h200);
    bad_access("lh_101",   1'b0, F3_H,   32'h101);

    // Timeout: ready never arrives.
    access(1'b0, F3_W, 32'h300, 32'h0, 32'h1234_5678, -1);
    check("to_busy_cycles", r_busy, TO);
    check("to_bus_err",     {31'b0, r_err}, 32'd1);
    check("to_load_data",   r_ld, 32'h0);
    check("to_stalls",      r_stalls, TO + 1);

    // Ready on the last allowed BUSY cycle wins over the timeout.
    access(1'b0, F3_W, 32'h300, 32'h0, 32'hCAFE_F00D, TO - 1);
    check("edge_busy_cycles", r_busy, TO);
    check("edge_bus_err",     {31'b0, r_err}, 32'd0);
    check("edge_load_data",   r_ld, 32'hCAFE_F00D);

    // Reset in the middle of BUSY.
    @(posedge clk); #1;
    mem_req = 1'b1; MemRW = 1'b0; Fun3 = F3_W; addr = 32'h400;
    Data_in = 32'h5555_AAAA; MIO_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("mid_busy_bus_req", {31'b0, bus_req}, 32'd1);
    rst_n = 1'b0; mem_req = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1; MIO_ready = 1'b1;
    @(negedge clk);
    check("mid_rst_bus_req", {31'b0, bus_req}, 32'd0);
    check("mid_rst_stall",   {31'b0, stall},   32'd0);
    lv_seen = int'(load_valid);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      lv_seen += int'(load_valid);
    end
    check("mid_rst_no_load_valid", lv_seen, 0);
    check("mid_rst_load_data",     load_data, 32'h0);
    MIO_ready = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
